// File: rtl/cosim_pkg.sv
// cosim_pkg: shared types and constants for the cosim trace buffer.
//   XLEN / DEC_W / SEQ_W fix the width of trace_entry_t, so they live here and
//   not as per-instance parameters.
//   OVF_DROP_ALL / OVF_KEEP_FIT are the two overflow policies.
`timescale 1ns/1ps
package cosim_pkg;

    localparam int XLEN  = 32;
    localparam int DEC_W = 32;
    localparam int SEQ_W = 16;

    localparam int OVF_DROP_ALL = 0;  // group does not fit -> whole group lost
    localparam int OVF_KEEP_FIT = 1;  // keep the lowest lanes that fit

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [DEC_W-1:0] dec;
    } trace_entry_t;

endpackage

// File: rtl/trace_lane_compact.sv
// trace_lane_compact: combinational lane compaction for the trace buffer.
//   lane_valid_i  per-lane valid bits
//   free_i        free FIFO slots, taken from registered occupancy
//   offset_o      per-lane slot offset (number of valid lanes below it)
//   accept_o      per-lane accepted mask after the overflow policy
//   n_valid_o     popcount of lane_valid_i
//   n_accept_o    number of accepted records
`timescale 1ns/1ps
module trace_lane_compact
    import cosim_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 16,
    parameter int OVF_MODE  = OVF_DROP_ALL,
    parameter int LW        = $clog2(NUM_LANES + 1),
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic [NUM_LANES-1:0] lane_valid_i,
    input  logic [CW-1:0]        free_i,
    output logic [LW-1:0]        offset_o [NUM_LANES],
    output logic [NUM_LANES-1:0] accept_o,
    output logic [LW-1:0]        n_valid_o,
    output logic [LW-1:0]        n_accept_o
);

    logic fits_all;

    // Running prefix count: each lane's slot is the number of valid lanes below it.
    always_comb begin
        n_valid_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            offset_o[i] = n_valid_o;
            n_valid_o   = n_valid_o + LW'(lane_valid_i[i]);
        end
    end

    assign fits_all = CW'(n_valid_o) <= free_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_accept
            if (OVF_MODE == OVF_KEEP_FIT) begin : g_fit
                // Lanes whose compacted slot lands inside the free space survive.
                assign accept_o[gi] = lane_valid_i[gi] && (CW'(offset_o[gi]) < free_i);
            end else begin : g_all
                assign accept_o[gi] = lane_valid_i[gi] && fits_all;
            end
        end

        if (OVF_MODE == OVF_KEEP_FIT) begin : g_n_fit
            // free_i < n_valid_o <= NUM_LANES in the else branch, so the narrowing is exact.
            assign n_accept_o = fits_all ? n_valid_o : LW'(free_i);
        end else begin : g_n_all
            assign n_accept_o = fits_all ? n_valid_o : '0;
        end
    endgenerate

endmodule

// File: rtl/cosim_trace_buffer.sv
// cosim_trace_buffer: multi-lane retire capture FIFO feeding the cosim checker.
//   clk, rst           clock, asynchronous active-high reset
//   lane_valid/pc/instr/dec  up to NUM_LANES records per cycle, lane 0 oldest
//   in_ready           advisory: at least NUM_LANES free slots
//   flush              synchronous clear of contents (seq/drop stats kept)
//   out_valid/ready    head handshake; out_entry is the head record
//   count              occupancy
//   drop_cnt           saturating count of records lost to overflow
//   overflow           sticky flag, set on first lost record
`timescale 1ns/1ps
module cosim_trace_buffer
    import cosim_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16,
    parameter int OVF_MODE  = OVF_DROP_ALL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES-1:0]          lane_valid,
    input  logic [NUM_LANES*XLEN-1:0]     lane_pc,
    input  logic [NUM_LANES*XLEN-1:0]     lane_instr,
    input  logic [NUM_LANES*DEC_W-1:0]    lane_dec,
    output logic                          in_ready,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output trace_entry_t                  out_entry,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic                          overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(NUM_LANES + 1);

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    trace_entry_t     mem_q [DEPTH];
    trace_entry_t     lane_entry [NUM_LANES];

    logic [CW-1:0]        free_slots;
    logic [LW-1:0]        offset [NUM_LANES];
    logic [NUM_LANES-1:0] accept;
    logic [LW-1:0]        n_valid, n_accept, n_drop;
    logic [CNT_W:0]       drop_sum;
    logic                 pop;

    // Space is judged on registered occupancy only: a same-cycle pop frees nothing,
    // which keeps out_ready out of the accept path.
    assign free_slots = CW'(DEPTH) - count_q;

    trace_lane_compact #(
        .NUM_LANES (NUM_LANES),
        .DEPTH     (DEPTH),
        .OVF_MODE  (OVF_MODE),
        .LW        (LW),
        .CW        (CW)
    ) u_compact (
        .lane_valid_i (lane_valid),
        .free_i       (free_slots),
        .offset_o     (offset),
        .accept_o     (accept),
        .n_valid_o    (n_valid),
        .n_accept_o   (n_accept)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_entry
            assign lane_entry[gi] = '{
                seq:   seq_q + SEQ_W'(offset[gi]),
                pc:    lane_pc[gi*XLEN +: XLEN],
                instr: lane_instr[gi*XLEN +: XLEN],
                dec:   lane_dec[gi*DEC_W +: DEC_W]
            };
        end
    endgenerate

    assign pop      = (count_q != '0) && out_ready && !flush;
    assign n_drop   = n_valid - n_accept;
    assign drop_sum = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (flush) begin
            // Lanes presented alongside flush are discarded silently: no seq, no drops.
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(n_accept) - CW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(n_accept);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            seq_d    = seq_q + SEQ_W'(n_accept);
            if (n_drop != '0) begin
                overflow_d = 1'b1;
                drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (accept[i]) begin
                    mem_q[wr_ptr_q + PW'(offset[i])] <= lane_entry[i];
                end
            end
        end
    end

    assign out_entry = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign in_ready  = (free_slots >= CW'(NUM_LANES));
    assign count     = count_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cosim_trace_buffer.sv
`timescale 1ns/1ps
module tb_cosim_trace_buffer;
    import cosim_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   lane_valid;
    logic [63:0]  lane_pc, lane_instr, lane_dec;
    logic         flush, out_ready;

    logic         in_ready0, out_valid0, overflow0;
    trace_entry_t out_entry0;
    logic [3:0]   count0;
    logic [15:0]  drop_cnt0;

    logic         in_ready1, out_valid1, overflow1;
    trace_entry_t out_entry1;
    logic [3:0]   count1;
    logic [1:0]   drop_cnt1;

    int errors = 0;
    int checks = 0;

    // Drop-whole-group instance.
    cosim_trace_buffer #(.NUM_LANES(2), .DEPTH(8), .CNT_W(16), .OVF_MODE(0)) u0 (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_pc(lane_pc),
        .lane_instr(lane_instr), .lane_dec(lane_dec), .in_ready(in_ready0),
        .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
        .out_entry(out_entry0), .count(count0), .drop_cnt(drop_cnt0),
        .overflow(overflow0));

    // Keep-what-fits instance with a tiny drop counter to reach saturation.
    cosim_trace_buffer #(.NUM_LANES(2), .DEPTH(8), .CNT_W(2), .OVF_MODE(1)) u1 (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_pc(lane_pc),
        .lane_instr(lane_instr), .lane_dec(lane_dec), .in_ready(in_ready1),
        .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .out_entry(out_entry1), .count(count1), .drop_cnt(drop_cnt1),
        .overflow(overflow1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        lane_valid = v;
        lane_pc    = {pc1, pc0};
        lane_instr = {pc1 ^ 32'h1300_0000, pc0 ^ 32'h1300_0000};
        lane_dec   = {pc1 + 32'd1, pc0 + 32'd1};
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_lanes(2'b00, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid0); end
        checks++; if (count0 !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count0); end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready0); end
        checks++; if (drop_cnt0 !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt0); end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow0); end
        $display("reset: count=%0d out_valid=%b in_ready=%b", count0, out_valid0, in_ready0);
    endtask

    task automatic test_dual_push();
        set_lanes(2'b11, 32'h100, 32'h104); out_ready = 1'b0;
        step();
        set_lanes(2'b00, 32'h0, 32'h0);
        checks++; if (count0 !== 4'd2) begin errors++; $display("FAIL dual_count: got %0d expected 2", count0); end
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL dual_valid: got %b expected 1", out_valid0); end
        checks++; if (out_entry0.pc !== 32'h100) begin errors++; $display("FAIL dual_head_pc: got %h expected 100", out_entry0.pc); end
        checks++; if (out_entry0.seq !== 16'd0) begin errors++; $display("FAIL dual_head_seq: got %0d expected 0", out_entry0.seq); end
        checks++; if (out_entry0.instr !== 32'h1300_0100) begin errors++; $display("FAIL dual_head_instr: got %h expected 13000100", out_entry0.instr); end
        checks++; if (out_entry0.dec !== 32'h101) begin errors++; $display("FAIL dual_head_dec: got %h expected 101", out_entry0.dec); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_entry0.pc !== 32'h104) begin errors++; $display("FAIL dual_second_pc: got %h expected 104", out_entry0.pc); end
        checks++; if (out_entry0.seq !== 16'd1) begin errors++; $display("FAIL dual_second_seq: got %0d expected 1", out_entry0.seq); end
        checks++; if (count0 !== 4'd1) begin errors++; $display("FAIL dual_count_after_pop: got %0d expected 1", count0); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL dual_drained: got %b expected 0", out_valid0); end
        $display("dual_push: two records popped, count=%0d", count0);
    endtask

    task automatic test_gap();
        set_lanes(2'b10, 32'hdead, 32'h200);
        step();
        set_lanes(2'b00, 32'h0, 32'h0);
        checks++; if (count0 !== 4'd1) begin errors++; $display("FAIL gap_count: got %0d expected 1", count0); end
        checks++; if (out_entry0.pc !== 32'h200) begin errors++; $display("FAIL gap_pc: got %h expected 200", out_entry0.pc); end
        checks++; if (out_entry0.seq !== 16'd2) begin errors++; $display("FAIL gap_seq: got %0d expected 2", out_entry0.seq); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        $display("gap: lane1-only record pc=200 seq=2");
    endtask

    task automatic test_overflow();
        // Fill both instances to 7 entries, seq 3..9.
        for (int i = 0; i < 3; i++) begin
            set_lanes(2'b11, 32'h400 + 32'(16*i), 32'h404 + 32'(16*i));
            step();
        end
        set_lanes(2'b01, 32'h430, 32'h0);
        step();
        checks++; if (count0 !== 4'd7) begin errors++; $display("FAIL ovf_fill_count0: got %0d expected 7", count0); end
        checks++; if (count1 !== 4'd7) begin errors++; $display("FAIL ovf_fill_count1: got %0d expected 7", count1); end
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL ovf_in_ready: got %b expected 0", in_ready0); end
        // Two lanes into one free slot while popping.
        set_lanes(2'b11, 32'h500, 32'h504); out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count0 !== 4'd6) begin errors++; $display("FAIL ovf_m0_count: got %0d expected 6", count0); end
        checks++; if (drop_cnt0 !== 16'd2) begin errors++; $display("FAIL ovf_m0_drop: got %0d expected 2", drop_cnt0); end
        checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL ovf_m0_flag: got %b expected 1", overflow0); end
        checks++; if (count1 !== 4'd7) begin errors++; $display("FAIL ovf_m1_count: got %0d expected 7", count1); end
        checks++; if (drop_cnt1 !== 2'd1) begin errors++; $display("FAIL ovf_m1_drop: got %0d expected 1", drop_cnt1); end
        checks++; if (overflow1 !== 1'b1) begin errors++; $display("FAIL ovf_m1_flag: got %b expected 1", overflow1); end
        checks++; if (out_entry0.seq !== 16'd4) begin errors++; $display("FAIL ovf_head_seq: got %0d expected 4", out_entry0.seq); end
        // u0 has room for 2, u1 keeps only lane0.
        set_lanes(2'b11, 32'h600, 32'h604);
        step();
        checks++; if (count0 !== 4'd8) begin errors++; $display("FAIL ovf_m0_full: got %0d expected 8", count0); end
        checks++; if (count1 !== 4'd8) begin errors++; $display("FAIL ovf_m1_full: got %0d expected 8", count1); end
        // Both full: everything dropped; the 2-bit counter saturates at 3.
        step();
        set_lanes(2'b00, 32'h0, 32'h0);
        checks++; if (drop_cnt0 !== 16'd4) begin errors++; $display("FAIL ovf_m0_drop_full: got %0d expected 4", drop_cnt0); end
        checks++; if (drop_cnt1 !== 2'd3) begin errors++; $display("FAIL ovf_m1_drop_sat: got %0d expected 3", drop_cnt1); end
        checks++; if (count0 !== 4'd8) begin errors++; $display("FAIL ovf_m0_stay_full: got %0d expected 8", count0); end
        // After six pops the kept lane0 record (u1) versus the later group (u0).
        out_ready = 1'b1; repeat (6) step(); out_ready = 1'b0;
        checks++; if (out_entry1.pc !== 32'h500) begin errors++; $display("FAIL ovf_m1_kept_pc: got %h expected 500", out_entry1.pc); end
        checks++; if (out_entry1.seq !== 16'd10) begin errors++; $display("FAIL ovf_m1_kept_seq: got %0d expected 10", out_entry1.seq); end
        checks++; if (out_entry0.pc !== 32'h600) begin errors++; $display("FAIL ovf_m0_next_pc: got %h expected 600", out_entry0.pc); end
        checks++; if (out_entry0.seq !== 16'd10) begin errors++; $display("FAIL ovf_m0_next_seq: got %0d expected 10", out_entry0.seq); end
        out_ready = 1'b1; repeat (2) step(); out_ready = 1'b0;
        checks++; if (count0 !== 4'd0 || count1 !== 4'd0) begin errors++; $display("FAIL ovf_drain: got %0d/%0d expected 0/0", count0, count1); end
        $display("overflow: m0 drop=%0d m1 drop=%0d", drop_cnt0, drop_cnt1);
    endtask

    task automatic test_stream();
        int sent;
        int rcv;
        sent = 0; rcv = 0;
        rst = 1'b1; step(); rst = 1'b0; step();
        for (int cyc = 0; cyc < 200 && rcv < 20; cyc++) begin
            out_ready = (cyc % 2 == 0);
            if (sent < 20 && cyc % 2 == 0) begin
                if (sent % 3 == 0) set_lanes(2'b10, 32'h0, 32'h1000 + 32'(4*sent));
                else               set_lanes(2'b01, 32'h1000 + 32'(4*sent), 32'h0);
                sent++;
            end else begin
                set_lanes(2'b00, 32'h0, 32'h0);
            end
            if (out_valid0 && out_ready) begin
                checks++; if (out_entry0.seq !== 16'(rcv)) begin errors++; $display("FAIL stream_seq: got %0d expected %0d", out_entry0.seq, rcv); end
                checks++; if (out_entry0.pc !== 32'h1000 + 32'(4*rcv)) begin errors++; $display("FAIL stream_pc: got %h expected %h", out_entry0.pc, 32'h1000 + 32'(4*rcv)); end
                $display("stream: seq=%0d pc=%h", out_entry0.seq, out_entry0.pc);
                rcv++;
            end
            step();
        end
        out_ready = 1'b0;
        set_lanes(2'b00, 32'h0, 32'h0);
        checks++; if (rcv !== 20) begin errors++; $display("FAIL stream_received: got %0d expected 20", rcv); end
        checks++; if (drop_cnt0 !== 16'd0) begin errors++; $display("FAIL stream_drops: got %0d expected 0", drop_cnt0); end
        checks++; if (count0 !== 4'd0) begin errors++; $display("FAIL stream_empty: got %0d expected 0", count0); end
    endtask

    task automatic test_flush();
        set_lanes(2'b11, 32'h700, 32'h704); step();
        set_lanes(2'b11, 32'h708, 32'h70c); step();
        set_lanes(2'b01, 32'h710, 32'h0);   step();
        checks++; if (count0 !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count0); end
        flush = 1'b1; set_lanes(2'b11, 32'h800, 32'h804);
        step();
        flush = 1'b0; set_lanes(2'b00, 32'h0, 32'h0);
        checks++; if (count0 !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid0); end
        checks++; if (drop_cnt0 !== 16'd0) begin errors++; $display("FAIL flush_drop: got %0d expected 0", drop_cnt0); end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready0); end
        set_lanes(2'b01, 32'h900, 32'h0);
        step();
        set_lanes(2'b00, 32'h0, 32'h0);
        checks++; if (count0 !== 4'd1) begin errors++; $display("FAIL flush_next_count: got %0d expected 1", count0); end
        checks++; if (out_entry0.seq !== 16'd25) begin errors++; $display("FAIL flush_next_seq: got %0d expected 25", out_entry0.seq); end
        checks++; if (out_entry0.pc !== 32'h900) begin errors++; $display("FAIL flush_next_pc: got %h expected 900", out_entry0.pc); end
        $display("flush: next seq=%0d", out_entry0.seq);
    endtask

    task automatic test_reset_mid();
        // count 1 -> 3 -> 5 -> 7, then a dropped pair.
        set_lanes(2'b11, 32'ha00, 32'ha04);
        repeat (4) step();
        checks++; if (count0 !== 4'd7) begin errors++; $display("FAIL mid_pre_count: got %0d expected 7", count0); end
        checks++; if (drop_cnt0 !== 16'd2) begin errors++; $display("FAIL mid_pre_drop: got %0d expected 2", drop_cnt0); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count0 !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid0); end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready0); end
        checks++; if (drop_cnt0 !== 16'd0) begin errors++; $display("FAIL mid_drop: got %0d expected 0", drop_cnt0); end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", overflow0); end
        $display("reset_mid: count=%0d drop=%0d", count0, drop_cnt0);
        step();
        set_lanes(2'b00, 32'h0, 32'h0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_lanes(2'b00, 32'h0, 32'h0);
        test_reset();
        test_dual_push();
        test_gap();
        test_overflow();
        test_stream();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
